// File: rtl/mc_mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, funct codes,
// FSM state encoding and ALU control.
package mc_mips_pkg;

    localparam int NUM_REGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef logic [2:0] state_t;
    localparam state_t S_FETCH  = 3'd0;
    localparam state_t S_DECODE = 3'd1;
    localparam state_t S_EXEC   = 3'd2;
    localparam state_t S_MEM    = 3'd3;
    localparam state_t S_WB     = 3'd4;
    localparam state_t S_TRAP   = 3'd5;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    function automatic logic insn_legal(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
                    default: return 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Non-R-type instructions that use the ALU (addi, lw, sw) all add.
    function automatic alu_op_t alu_ctrl(input logic [5:0] op, input logic [5:0] funct);
        if (op != OP_RTYPE) return ALU_ADD;
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, asynchronous reset; register 0 always reads zero and ignores writes.
module mc_mips_regfile
    import mc_mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'h0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : regs[raddr2];

endmodule

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core with one unified req/ready memory port.
// Define MC_MIPS_TRAP_EN to halt on illegal instructions (adds the halted port).
module multicycle_mips
    import mc_mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic              instr_retired,
    output logic [2:0]        fsm_state
`ifdef MC_MIPS_TRAP_EN
    ,
    output logic              halted
`endif
);

    logic [31:0] pc_q, ir, a, b, alu_out, mdr;
    state_t      state;
    // Held low for the first cycle after reset so no request is issued during reset.
    logic        run;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_se, alu_b, alu_res, mem_addr_int;
    logic [31:0] rdata1, rdata2, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        rf_we, legal;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign imm_se = {{16{ir[15]}}, ir[15:0]};
    assign legal  = insn_legal(op, funct);

    mc_mips_regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    always_comb begin
        alu_b = (op == OP_RTYPE) ? b : imm_se;
        case (alu_ctrl(op, funct))
            ALU_SUB: alu_res = a - alu_b;
            ALU_AND: alu_res = a & alu_b;
            ALU_OR:  alu_res = a | alu_b;
            ALU_SLT: alu_res = {31'h0, $signed(a) < $signed(alu_b)};
            default: alu_res = a + alu_b;
        endcase
    end

    // Memory port: address/data depend only on state and registers, so they
    // stay stable across wait states.
    assign mem_req      = run && (state == S_FETCH || state == S_MEM);
    assign mem_we       = run && state == S_MEM && op == OP_SW;
    assign mem_addr_int = !mem_req ? 32'h0 : (state == S_MEM) ? alu_out : pc_q;
    assign mem_addr     = mem_addr_int[ADDR_W-1:0];
    assign mem_wdata    = mem_we ? b : 32'h0;
    assign pc           = pc_q;
    assign fsm_state    = state;

    always_comb begin
        instr_retired = 1'b0;
        case (state)
            S_DECODE: begin
                instr_retired = (op == OP_J) || (op == OP_JAL);
`ifdef MC_MIPS_TRAP_EN
`else
                if (!legal) instr_retired = 1'b1;
`endif
            end
            S_EXEC:  instr_retired = (op == OP_BEQ);
            S_MEM:   instr_retired = (op == OP_SW) && mem_ready;
            S_WB:    instr_retired = 1'b1;
            default: instr_retired = 1'b0;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'h0;
        if (state == S_DECODE && op == OP_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_q;
        end else if (state == S_WB) begin
            rf_we = 1'b1;
            case (op)
                OP_RTYPE: begin rf_waddr = rd; rf_wdata = alu_out; end
                OP_LW:    begin rf_waddr = rt; rf_wdata = mdr;     end
                default:  begin rf_waddr = rt; rf_wdata = alu_out; end
            endcase
        end
    end

`ifdef MC_MIPS_TRAP_EN
    assign halted = (state == S_TRAP);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ir      <= 32'h0;
            a       <= 32'h0;
            b       <= 32'h0;
            alu_out <= 32'h0;
            mdr     <= 32'h0;
            state   <= S_FETCH;
            run     <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc_q  <= pc_q + 32'd4;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a       <= rdata1;
                    b       <= rdata2;
                    alu_out <= pc_q + (imm_se << 2);
                    if (op == OP_J || op == OP_JAL) begin
                        pc_q  <= {pc_q[31:28], ir[25:0], 2'b00};
                        state <= S_FETCH;
                    end else if (!legal) begin
`ifdef MC_MIPS_TRAP_EN
                        pc_q  <= pc_q - 32'd4;
                        state <= S_TRAP;
`else
                        state <= S_FETCH;
`endif
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_BEQ: begin
                            if (a == b) pc_q <= alu_out;
                            state <= S_FETCH;
                        end
                        OP_LW, OP_SW: begin
                            alu_out <= alu_res;
                            state   <= S_MEM;
                        end
                        default: begin
                            alu_out <= alu_res;
                            state   <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op == OP_LW) begin
                            mdr   <= mem_rdata;
                            state <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_mips.sv
// Directed bench for multicycle_mips: bench-owned memory with programmable
// wait states, per-instruction fetch address and cycle-count checks.
module tb_multicycle_mips;
    import mc_mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, instr_retired;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [2:0]  fsm_state;
`ifdef MC_MIPS_TRAP_EN
    logic        halted;
`endif

    multicycle_mips #(.RESET_PC(32'h0000_0100), .ADDR_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .pc            (pc),
        .instr_retired (instr_retired),
        .fsm_state     (fsm_state)
`ifdef MC_MIPS_TRAP_EN
        ,
        .halted        (halted)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [128];
    int          waits = 0, wcnt = 0;
    int          errors = 0, checks = 0;

    logic        o_req, o_we, o_ret;
    logic [31:0] o_addr, o_wdata, o_pc;
    logic [31:0] last_waddr = 32'hFFFF_FFFF, last_wdata = 32'hFFFF_FFFF;
    logic [31:0] h_addr, h_data;
    logic        in_wr = 1'b0, wr_unstable = 1'b0;
    int          wr_cycles = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive the memory response at the falling edge, then sample the outputs.
    task automatic sample();
        @(negedge clk);
        mem_ready = mem_req && (wcnt >= waits);
        mem_rdata = mem_req ? mem[mem_addr[8:2]] : 32'h0;
        #1;
        o_req   = mem_req;
        o_we    = mem_we;
        o_addr  = mem_addr;
        o_wdata = mem_wdata;
        o_ret   = instr_retired;
        o_pc    = pc;
        if (o_req && o_we) begin
            if (!in_wr) begin
                in_wr       = 1'b1;
                h_addr      = o_addr;
                h_data      = o_wdata;
                wr_cycles   = 0;
                wr_unstable = 1'b0;
            end
            wr_cycles++;
            if (o_addr !== h_addr || o_wdata !== h_data) wr_unstable = 1'b1;
            if (mem_ready) in_wr = 1'b0;
        end
    endtask

    task automatic commit();
        @(posedge clk);
        if (o_req && mem_ready) begin
            if (o_we) begin
                mem[o_addr[8:2]] = o_wdata;
                last_waddr = o_addr;
                last_wdata = o_wdata;
            end
            wcnt = 0;
        end else if (o_req) begin
            wcnt++;
        end
    endtask

    // Run one instruction to its retire pulse; check fetch address and length.
    task automatic exec_instr(input string tag, input logic [31:0] exp_fetch, input int exp_cyc);
        int          n = 0;
        logic [31:0] faddr = 32'hFFFF_FFFF;
        logic        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            sample();
            if (i == 0 && o_req && !o_we) faddr = o_addr;
            n++;
            done = o_ret;
            commit();
        end
        check32({tag, " fetch_addr"}, faddr, exp_fetch);
        check32({tag, " cycles"}, 32'(n), 32'(exp_cyc));
    endtask

    initial begin
        logic found;
        int   reqs, rets;

        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEAD_BEEF;   // addr 0x10
        mem[5]  = 32'h0000_0055;   // addr 0x14
        mem[6]  = 32'h1234_5678;   // addr 0x18
        mem[8]  = 32'h1021_FFFF;   // 0x20 beq $1,$1,-1 (taken)
        mem[9]  = 32'h0800_000C;   // 0x24 j 0x30
        mem[12] = 32'h0C00_0040;   // 0x30 jal 0x100
        mem[20] = 32'hFC00_0000;   // 0x50 illegal opcode 0x3F
        mem[21] = 32'hAC01_0018;   // 0x54 sw $1,24($0)
        mem[22] = 32'h8C06_01F0;   // 0x58 lw $6,0x1F0($0)
        mem[64] = 32'h2001_0005;   // 0x100 addi $1,$0,5
        mem[65] = 32'h2002_FFF9;   // 0x104 addi $2,$0,-7
        mem[66] = 32'h0041_182A;   // 0x108 slt $3,$2,$1
        mem[67] = 32'h0022_2022;   // 0x10C sub $4,$1,$2
        mem[68] = 32'hAC03_0004;   // 0x110 sw $3,4($0)
        mem[69] = 32'hAC04_0008;   // 0x114 sw $4,8($0)
        mem[70] = 32'h8C05_0008;   // 0x118 lw $5,8($0)
        mem[71] = 32'hAC05_000C;   // 0x11C sw $5,12($0)
        mem[72] = 32'h2000_0009;   // 0x120 addi $0,$0,9
        mem[73] = 32'hAC00_0010;   // 0x124 sw $0,16($0)
        mem[74] = 32'h0800_0008;   // 0x128 j 0x20

        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check32("reset mem_req", {31'h0, mem_req}, 32'h0);
        check32("reset mem_we", {31'h0, mem_we}, 32'h0);
        check32("reset mem_addr", mem_addr, 32'h0);
        check32("reset mem_wdata", mem_wdata, 32'h0);
        check32("reset pc", pc, 32'h100);
        check32("reset retired", {31'h0, instr_retired}, 32'h0);
        check32("reset state", {29'h0, fsm_state}, {29'h0, S_FETCH});
        reset = 1'b0;

        // Arithmetic, zero wait states
        exec_instr("addi1", 32'h100, 4);
        exec_instr("addi2", 32'h104, 4);
        exec_instr("slt", 32'h108, 4);
        exec_instr("sub", 32'h10C, 4);
        exec_instr("sw_slt", 32'h110, 4);
        check32("slt result addr", last_waddr, 32'h4);
        check32("slt result", last_wdata, 32'h1);

        // Load/store with 3 wait cycles per transfer
        waits = 3;
        exec_instr("sw_wait", 32'h114, 10);
        check32("sw_wait addr", last_waddr, 32'h8);
        check32("sw_wait data", last_wdata, 32'd12);
        check32("sw_wait hold_cycles", 32'(wr_cycles), 32'd4);
        check32("sw_wait stable", {31'h0, wr_unstable}, 32'h0);
        exec_instr("lw_wait", 32'h118, 11);
        waits = 0;
        exec_instr("sw_lw", 32'h11C, 4);
        check32("lw value addr", last_waddr, 32'hC);
        check32("lw value", last_wdata, 32'd12);

        // $0 stays zero
        exec_instr("addi_r0", 32'h120, 4);
        exec_instr("sw_r0", 32'h124, 4);
        check32("r0 addr", last_waddr, 32'h10);
        check32("r0 value", last_wdata, 32'h0);

        // Branches and jumps
        exec_instr("j20", 32'h128, 2);
        exec_instr("beq_taken", 32'h20, 3);
        mem[8] = 32'h1022_FFFF;    // beq $1,$2,-1 (not taken)
        exec_instr("beq_loop_target", 32'h20, 3);
        exec_instr("beq_not_taken", 32'h24, 2);
        exec_instr("jal", 32'h30, 2);
        mem[64] = 32'hAC1F_0014;   // sw $31,20($0)
        mem[65] = 32'h0800_0016;   // j 0x58
        exec_instr("jal_target", 32'h100, 4);
        check32("jal link addr", last_waddr, 32'h14);
        check32("jal link", last_wdata, 32'h34);
        exec_instr("j58", 32'h104, 2);

        // Reset in the middle of a stalled load
        waits = 6;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (o_req && o_addr == 32'h1F0 && !mem_ready) begin
                found = 1'b1;
                break;
            end
            commit();
        end
        check32("lw reached MEM", {31'h0, found}, 32'h1);
        reset = 1'b1;
        #1;
        check32("midreset mem_req", {31'h0, mem_req}, 32'h0);
        check32("midreset retired", {31'h0, instr_retired}, 32'h0);
        check32("midreset pc", pc, 32'h100);
        mem_ready = 1'b0;
        waits = 0;
        wcnt = 0;
        in_wr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exec_instr("restart", 32'h100, 4);
        check32("restart regfile cleared", last_wdata, 32'h0);
        mem[65] = 32'h0800_0014;   // j 0x50
        exec_instr("j50", 32'h104, 2);

        // Illegal opcode at 0x50
`ifdef MC_MIPS_TRAP_EN
        sample();
        check32("illegal fetch_addr", o_addr, 32'h50);
        commit();
        reqs = 0;
        rets = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            reqs += int'(o_req);
            rets += int'(o_ret);
            commit();
        end
        check32("trap mem_req count", 32'(reqs), 32'h0);
        check32("trap retire count", 32'(rets), 32'h0);
        check32("trap halted", {31'h0, halted}, 32'h1);
        check32("trap pc", pc, 32'h50);
`else
        reqs = 0;
        rets = 0;
        exec_instr("illegal_nop", 32'h50, 2);
        exec_instr("after_nop", 32'h54, 4);
        check32("after_nop addr", last_waddr, 32'h18);
        check32("after_nop data", last_wdata, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
